ldtbl_db: RTL and testbench

- Parametrised, double-buffered successor of the per-function load/map table in the SMA control path.
- Holds NBANK=2 banks of DEPTH entries. Each entry is ENTRY_W load-table bits plus MAP_W map bits.
- The datapath looks up the active bank by function code. The host bus writes/reads the shadow bank, then commits it with a swap handshake applied only at a safe (lookup-idle) point.
- A sequential copy engine can clone the active bank into the shadow bank for incremental edits.

---
 rtl/ldtbl_db_pkg.sv | 23 ++
 rtl/ldtbl_bank.sv | 70 +++++++
 rtl/ldtbl_db.sv | 213 +++++++++++++++++++++
 tb/tb_ldtbl_db.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ldtbl_db_pkg.sv
// Shared constants and types for the double-buffered load/map table.
// The defaults mirror the SMA control-path table geometry.
package ldtbl_db_pkg;

  localparam int unsigned LDTBL_W     = 48;
  localparam int unsigned MAP_W_DFLT  = 12;
  localparam int unsigned DATA_W_DFLT = 24;
  localparam int unsigned DEPTH_DFLT  = 16;
  localparam int unsigned NBANK       = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SWAP_WAIT = 2'd1,
    ST_COPY      = 2'd2
  } state_e;

  // Number of host-bus segments needed to cover one entry.
  function automatic int unsigned seg_count(input int unsigned entry_w,
                                            input int unsigned data_w);
    return (entry_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/ldtbl_bank.sv
// One table bank: a masked write port and two asynchronous read ports.
// Indices at or beyond DEPTH write nothing and read as zero.
module ldtbl_bank
  import ldtbl_db_pkg::*;
#(
  parameter int unsigned ENTRY_W = LDTBL_W,
  parameter int unsigned MAP_W   = MAP_W_DFLT,
  parameter int unsigned DEPTH   = DEPTH_DFLT,
  parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_widx,
  input  logic [ENTRY_W-1:0] i_wmask,
  input  logic [ENTRY_W-1:0] i_went,
  input  logic               i_wmap_en,
  input  logic [MAP_W-1:0]   i_wmap,
  input  logic [IDX_W-1:0]   i_ra_idx,
  output logic [ENTRY_W-1:0] o_ra_ent,
  output logic [MAP_W-1:0]   o_ra_map,
  input  logic [IDX_W-1:0]   i_rb_idx,
  output logic [ENTRY_W-1:0] o_rb_ent,
  output logic [MAP_W-1:0]   o_rb_map
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] ent_q [DEPTH];
  logic [ENTRY_W-1:0] ent_d [DEPTH];
  logic [MAP_W-1:0]   map_q [DEPTH];
  logic [MAP_W-1:0]   map_d [DEPTH];

  always_comb begin
    ent_d = ent_q;
    map_d = map_q;
    if (i_we && ({1'b0, i_widx} < DEPTH_L)) begin
      ent_d[i_widx] = (ent_q[i_widx] & ~i_wmask) | (i_went & i_wmask);
      if (i_wmap_en) begin
        map_d[i_widx] = i_wmap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '{default: '0};
      map_q <= '{default: '0};
    end else begin
      ent_q <= ent_d;
      map_q <= map_d;
    end
  end

  always_comb begin
    o_ra_ent = '0;
    o_ra_map = '0;
    o_rb_ent = '0;
    o_rb_map = '0;
    if ({1'b0, i_ra_idx} < DEPTH_L) begin
      o_ra_ent = ent_q[i_ra_idx];
      o_ra_map = map_q[i_ra_idx];
    end
    if ({1'b0, i_rb_idx} < DEPTH_L) begin
      o_rb_ent = ent_q[i_rb_idx];
      o_rb_map = map_q[i_rb_idx];
    end
  end

endmodule

// File: rtl/ldtbl_db.sv
// Double-buffered load/map table: lookups hit the active bank, the host edits
// the shadow bank, and a swap commits it once the lookup pipe is empty.
module ldtbl_db
  import ldtbl_db_pkg::*;
#(
  parameter  int unsigned ENTRY_W = LDTBL_W,
  parameter  int unsigned MAP_W   = MAP_W_DFLT,
  parameter  int unsigned DATA_W  = DATA_W_DFLT,
  parameter  int unsigned DEPTH   = DEPTH_DFLT,
  parameter  int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned NSEG    = seg_count(ENTRY_W, DATA_W),
  localparam int unsigned SEG_AW  = $clog2(NSEG + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_func_vld,
  input  logic [IDX_W-1:0]        i_func,
  output logic                    o_ldtbl_vld,
  output logic [ENTRY_W-1:0]      o_ldtblout,
  output logic [MAP_W-1:0]        o_mapout,
  input  logic                    i_exwe,
  input  logic                    i_exre,
  input  logic [IDX_W+SEG_AW-1:0] i_exa,
  input  logic [DATA_W-1:0]       i_exwd,
  output logic                    o_exready,
  output logic                    o_exrvld,
  output logic [DATA_W-1:0]       o_exrd,
  input  logic                    i_swap_req,
  output logic                    o_swap_ack,
  input  logic                    i_copy_req,
  output logic                    o_busy,
  output logic                    o_active
);

  localparam int unsigned WIDE_W = NSEG * DATA_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               active_q, active_d;
  logic               ack_q, ack_d;
  logic               lk_vld_q, lk_vld_d;
  logic [ENTRY_W-1:0] lk_ent_q, lk_ent_d;
  logic [MAP_W-1:0]   lk_map_q, lk_map_d;
  logic               rvld_q, rvld_d;
  logic [DATA_W-1:0]  rd_q, rd_d;

  logic [SEG_AW-1:0]  ex_seg;
  logic [IDX_W-1:0]   ex_idx;
  logic               ready, host_wr, host_rd, copy_wr, wr_en, map_hit;
  logic [WIDE_W-1:0]  seg_mask_w, wd_wide, sh_wide;
  logic [DATA_W-1:0]  rd_word;
  logic [IDX_W-1:0]   wr_idx;
  logic [ENTRY_W-1:0] wr_mask, wr_ent;
  logic               wr_map_en;
  logic [MAP_W-1:0]   wr_map;

  logic [NBANK-1:0]   bank_we;
  logic [IDX_W-1:0]   rb_idx [NBANK];
  logic [ENTRY_W-1:0] ra_ent [NBANK];
  logic [MAP_W-1:0]   ra_map [NBANK];
  logic [ENTRY_W-1:0] rb_ent [NBANK];
  logic [MAP_W-1:0]   rb_map [NBANK];

  assign ex_seg = i_exa[SEG_AW-1:0];
  assign ex_idx = i_exa[IDX_W+SEG_AW-1:SEG_AW];

  // Port B of the active bank feeds the copy engine; on the shadow bank it serves host reads.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign bank_we[b] = wr_en & (active_q != 1'(b));
    assign rb_idx[b]  = (active_q == 1'(b)) ? cnt_q : ex_idx;

    ldtbl_bank #(
      .ENTRY_W (ENTRY_W),
      .MAP_W   (MAP_W),
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (bank_we[b]),
      .i_widx    (wr_idx),
      .i_wmask   (wr_mask),
      .i_went    (wr_ent),
      .i_wmap_en (wr_map_en),
      .i_wmap    (wr_map),
      .i_ra_idx  (i_func),
      .o_ra_ent  (ra_ent[b]),
      .o_ra_map  (ra_map[b]),
      .i_rb_idx  (rb_idx[b]),
      .o_rb_ent  (rb_ent[b]),
      .o_rb_map  (rb_map[b])
    );
  end

  always_comb begin
    ready   = (state_q == ST_IDLE);
    host_wr = i_exwe & ready;
    host_rd = i_exre & ~i_exwe & ready;
    copy_wr = (state_q == ST_COPY);
    wr_en   = host_wr | copy_wr;
    map_hit = (ex_seg == SEG_AW'(NSEG));

    seg_mask_w = '0;
    rd_word    = '0;
    wd_wide    = {NSEG{i_exwd}};
    sh_wide    = WIDE_W'(rb_ent[~active_q]);
    for (int unsigned k = 0; k < NSEG; k++) begin
      if (ex_seg == SEG_AW'(k)) begin
        seg_mask_w[k*DATA_W +: DATA_W] = '1;
        rd_word = sh_wide[k*DATA_W +: DATA_W];
      end
    end
    if (map_hit) begin
      rd_word = DATA_W'(rb_map[~active_q]);
    end

    if (copy_wr) begin
      wr_idx    = cnt_q;
      wr_mask   = '1;
      wr_ent    = rb_ent[active_q];
      wr_map_en = 1'b1;
      wr_map    = rb_map[active_q];
    end else begin
      wr_idx    = ex_idx;
      wr_mask   = seg_mask_w[ENTRY_W-1:0];
      wr_ent    = wd_wide[ENTRY_W-1:0];
      wr_map_en = map_hit;
      wr_map    = i_exwd[MAP_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    active_d = active_q;
    ack_d    = 1'b0;

    lk_vld_d = i_func_vld;
    lk_ent_d = i_func_vld ? ra_ent[active_q] : lk_ent_q;
    lk_map_d = i_func_vld ? ra_map[active_q] : lk_map_q;
    rvld_d   = host_rd;
    rd_d     = host_rd ? rd_word : rd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_copy_req) begin
          state_d = ST_COPY;
          cnt_d   = '0;
          pend_d  = i_swap_req;
        end else if (i_swap_req) begin
          state_d = ST_SWAP_WAIT;
        end
      end
      ST_COPY: begin
        pend_d = pend_q | i_swap_req;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = (pend_q | i_swap_req) ? ST_SWAP_WAIT : ST_IDLE;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SWAP_WAIT: begin
        // The ack is registered so it appears in the same cycle as the new o_active.
        if (!i_func_vld && !lk_vld_q) begin
          active_d = ~active_q;
          ack_d    = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      active_q <= 1'b0;
      ack_q    <= 1'b0;
      lk_vld_q <= 1'b0;
      lk_ent_q <= '0;
      lk_map_q <= '0;
      rvld_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      ack_q    <= ack_d;
      lk_vld_q <= lk_vld_d;
      lk_ent_q <= lk_ent_d;
      lk_map_q <= lk_map_d;
      rvld_q   <= rvld_d;
      rd_q     <= rd_d;
    end
  end

  assign o_ldtbl_vld = lk_vld_q;
  assign o_ldtblout  = lk_ent_q;
  assign o_mapout    = lk_map_q;
  assign o_exready   = ready;
  assign o_exrvld    = rvld_q;
  assign o_exrd      = rd_q;
  assign o_swap_ack  = ack_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_active    = active_q;

endmodule

// File: tb/tb_ldtbl_db.sv
// Directed bench for ldtbl_db: vector table for host/lookup access, plus
// hand-written swap, copy, copy+swap and reset-abort sequences.
module tb_ldtbl_db;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_func_vld;
  logic [3:0]  i_func;
  logic        o_ldtbl_vld;
  logic [47:0] o_ldtblout;
  logic [11:0] o_mapout;
  logic        i_exwe, i_exre;
  logic [5:0]  i_exa;
  logic [23:0] i_exwd;
  logic        o_exready, o_exrvld;
  logic [23:0] o_exrd;
  logic        i_swap_req, o_swap_ack, i_copy_req, o_busy, o_active;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  ldtbl_db dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_func_vld  (i_func_vld),
    .i_func      (i_func),
    .o_ldtbl_vld (o_ldtbl_vld),
    .o_ldtblout  (o_ldtblout),
    .o_mapout    (o_mapout),
    .i_exwe      (i_exwe),
    .i_exre      (i_exre),
    .i_exa       (i_exa),
    .i_exwd      (i_exwd),
    .o_exready   (o_exready),
    .o_exrvld    (o_exrvld),
    .o_exrd      (o_exrd),
    .i_swap_req  (i_swap_req),
    .o_swap_ack  (o_swap_ack),
    .i_copy_req  (i_copy_req),
    .o_busy      (o_busy),
    .o_active    (o_active)
  );

  typedef struct {
    logic        we, re, fv;
    logic [3:0]  func;
    logic [5:0]  exa;
    logic [23:0] wd;
    logic        e_lv;
    logic [47:0] e_ent;
    logic [11:0] e_map;
    logic        e_rv;
    logic [23:0] e_rd;
  } vec_t;

  vec_t vt [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_func_vld = 1'b0; i_func = '0; i_exwe = 1'b0; i_exre = 1'b0;
    i_exa = '0; i_exwd = '0; i_swap_req = 1'b0; i_copy_req = 1'b0;
  endtask

  task automatic host_read(input logic [5:0] a, input logic [23:0] exp, input string nm);
    i_exre = 1'b1; i_exa = a;
    step();
    i_exre = 1'b0;
    chk({nm, "_rvld"}, 64'(o_exrvld), 64'd1);
    chk(nm, 64'(o_exrd), 64'(exp));
  endtask

  task automatic lookup(input logic [3:0] f, input logic [47:0] e_ent,
                        input logic [11:0] e_map, input string nm);
    i_func_vld = 1'b1; i_func = f;
    step();
    i_func_vld = 1'b0;
    chk({nm, "_vld"}, 64'(o_ldtbl_vld), 64'd1);
    chk({nm, "_ent"}, 64'(o_ldtblout), 64'(e_ent));
    chk({nm, "_map"}, 64'(o_mapout), 64'(e_map));
  endtask

  initial begin
    int unsigned busy_cnt, ack_cnt, ack_at;
    logic        rdy_bad;

    // exa = {idx[3:0], seg[1:0]}
    vt[0]  = '{1'b0, 1'b0, 1'b1, 4'd3, 6'h00, 24'h0,      1'b1, 48'h0, 12'h0, 1'b0, 24'h0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 6'h0C, 24'hABCDEF, 1'b0, 48'h0, 12'h0, 1'b0, 24'h0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 6'h0D, 24'h123456, 1'b0, 48'h0, 12'h0, 1'b0, 24'h0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 6'h0E, 24'hFFF5A5, 1'b0, 48'h0, 12'h0, 1'b0, 24'h0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 4'd3, 6'h00, 24'h0,      1'b1, 48'h0, 12'h0, 1'b0, 24'h0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h0D, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'h123456};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h0E, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'h0005A5};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h0C, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'hABCDEF};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 6'h3F, 24'h777777, 1'b0, 48'h0, 12'h0, 1'b0, 24'hABCDEF};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h3F, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'h0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 4'd0, 6'h14, 24'h111111, 1'b0, 48'h0, 12'h0, 1'b0, 24'h0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h14, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'h111111};
    vt[12] = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h17, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'h0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 4'd0, 6'h15, 24'hFEDCBA, 1'b0, 48'h0, 12'h0, 1'b0, 24'h0};
    vt[14] = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h15, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'hFEDCBA};
    vt[15] = '{1'b0, 1'b1, 1'b0, 4'd0, 6'h3C, 24'h0,      1'b0, 48'h0, 12'h0, 1'b1, 24'h0};

    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    chk("rst_lvld",   64'(o_ldtbl_vld), 64'd0);
    chk("rst_ent",    64'(o_ldtblout),  64'd0);
    chk("rst_ready",  64'(o_exready),   64'd1);
    chk("rst_rvld",   64'(o_exrvld),    64'd0);
    chk("rst_ack",    64'(o_swap_ack),  64'd0);
    chk("rst_busy",   64'(o_busy),      64'd0);
    chk("rst_active", 64'(o_active),    64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      i_exwe = vt[i].we; i_exre = vt[i].re; i_func_vld = vt[i].fv;
      i_func = vt[i].func; i_exa = vt[i].exa; i_exwd = vt[i].wd;
      step();
      chk($sformatf("v%0d_lvld", i), 64'(o_ldtbl_vld), 64'(vt[i].e_lv));
      chk($sformatf("v%0d_ent", i),  64'(o_ldtblout),  64'(vt[i].e_ent));
      chk($sformatf("v%0d_map", i),  64'(o_mapout),    64'(vt[i].e_map));
      chk($sformatf("v%0d_rvld", i), 64'(o_exrvld),    64'(vt[i].e_rv));
      chk($sformatf("v%0d_rd", i),   64'(o_exrd),      64'(vt[i].e_rd));
    end
    idle_inputs();

    // Swap held off by five cycles of lookups, then acked once the pipe drains.
    i_swap_req = 1'b1; i_func_vld = 1'b1; i_func = 4'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      i_swap_req = 1'b0;
      chk($sformatf("swhold%0d_ack", i), 64'(o_swap_ack), 64'd0);
      chk($sformatf("swhold%0d_busy", i), 64'(o_busy), 64'd1);
    end
    i_func_vld = 1'b0;
    step();
    chk("swdrain_ack", 64'(o_swap_ack), 64'd0);
    chk("swdrain_act", 64'(o_active),   64'd0);
    step();
    chk("sw_ack",    64'(o_swap_ack), 64'd1);
    chk("sw_active", 64'(o_active),   64'd1);
    chk("sw_busy",   64'(o_busy),     64'd0);
    step();
    chk("sw_ack_pulse", 64'(o_swap_ack), 64'd0);
    lookup(4'd3, 48'h123456ABCDEF, 12'h5A5, "post_sw3");
    step();
    chk("hold_vld", 64'(o_ldtbl_vld), 64'd0);
    chk("hold_ent", 64'(o_ldtblout),  64'h123456ABCDEF);
    chk("hold_map", 64'(o_mapout),    64'h5A5);
    lookup(4'd5, 48'hFEDCBA111111, 12'h0, "post_sw5");

    // Copy active (bank 1) into shadow (bank 0) while a host write is dropped.
    busy_cnt = 0; ack_cnt = 0; rdy_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_copy_req = (i == 0);
      i_exwe = (i >= 4 && i <= 13); i_exa = 6'h0C; i_exwd = 24'h999999;
      step();
      if (o_busy) busy_cnt++;
      if (o_swap_ack) ack_cnt++;
      if (o_exready == o_busy) rdy_bad = 1'b1;
    end
    idle_inputs();
    chk("copy_busy_cycles", 64'(busy_cnt), 64'd16);
    chk("copy_no_ack",      64'(ack_cnt),  64'd0);
    chk("copy_ready_inv",   64'(rdy_bad),  64'd0);
    chk("copy_active",      64'(o_active), 64'd1);
    host_read(6'h0C, 24'hABCDEF, "copy_i3s0");
    host_read(6'h0D, 24'h123456, "copy_i3s1");
    host_read(6'h0E, 24'h0005A5, "copy_i3map");
    host_read(6'h15, 24'hFEDCBA, "copy_i5s1");

    // Copy and swap together; a second swap inside SWAP_WAIT must not re-toggle.
    ack_cnt = 0; ack_at = 99; busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      i_copy_req = (i == 0);
      i_swap_req = (i == 0) || (i == 18);
      i_func_vld = (i < 22); i_func = 4'd0;
      step();
      if (o_busy) busy_cnt++;
      if (o_swap_ack) begin
        ack_cnt++;
        ack_at = i;
      end
    end
    idle_inputs();
    chk("cs_ack_count", 64'(ack_cnt),  64'd1);
    chk("cs_ack_at",    64'(ack_at),   64'd23);
    chk("cs_busy",      64'(busy_cnt), 64'd23);
    chk("cs_active",    64'(o_active), 64'd0);
    lookup(4'd3, 48'h123456ABCDEF, 12'h5A5, "cs_look3");

    // Reset in the middle of a copy aborts everything.
    i_copy_req = 1'b1;
    step();
    i_copy_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rc_busy_pre", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    step();
    chk("rc_busy",   64'(o_busy),     64'd0);
    chk("rc_active", 64'(o_active),   64'd0);
    chk("rc_ready",  64'(o_exready),  64'd1);
    chk("rc_ack",    64'(o_swap_ack), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rc_busy_post", 64'(o_busy), 64'd0);
    lookup(4'd3, 48'h0, 12'h0, "rc_look3");
    host_read(6'h0D, 24'h0, "rc_shadow_i3s1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
